// File: rtl/pll_rst_seq_pkg.sv
// Shared types for the DDR3 PLL reset sequencer: state encoding and retry counter width.
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int RETRY_W = 2;

endpackage

// File: rtl/pll_rst_seq_sync_2ff.sv
// Single-bit two-flop synchronizer for bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// DDR3 PLL bring-up sequencer: reset, lock wait with timeout, lock qualification, retry/fail.
// Optional lock-loss counter output is enabled by defining PLL_RST_SEQ_LOSS_CNT_EN.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_STABLE    = 1024,
  parameter int RETRY_MAX      = 3,
  parameter int CNT_W          = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_lock,
  input  logic               relock_req,
  output logic               pll_reset,
  output logic               pll_pwd,
  output logic               ddr_rst,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0]         lock_loss_cnt
`endif
);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(RETRY_MAX);

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [RETRY_W-1:0] retry_q, retry_nxt;
  logic               retry_inc, retry_clr;
  logic               lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign retry_nxt = retry_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= PLL_RST;
    else       state_q <= state_nxt;
  end

  // Next-state logic; retry bookkeeping is flagged here so it lines up with transitions.
  always_comb begin
    state_nxt = state_q;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_inc = 1'b1;
          state_nxt = (retry_nxt == RETRY_LIM) ? FAIL : PLL_RST;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_nxt = RUN;
          retry_clr = 1'b1;
        end
      end
      RUN: begin
        if (!lock_s || relock_req) state_nxt = PLL_RST;
      end
      FAIL: begin
        if (relock_req) begin
          state_nxt = PLL_RST;
          retry_clr = 1'b1;
        end
      end
      default: state_nxt = PLL_RST;
    endcase
  end

  // Shared cycle counter restarts on every state entry and saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset)                       cnt_q <= '0;
    else if (state_nxt != state_q)   cnt_q <= '0;
    else if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)                           retry_q <= '0;
    else if (retry_clr)                  retry_q <= '0;
    else if (retry_inc && retry_q != '1) retry_q <= retry_nxt;
  end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic loss_evt;
  assign loss_evt = (state_q == RUN) && !lock_s;

  always_ff @(posedge clk) begin
    if (reset)                               lock_loss_cnt <= 8'd0;
    else if (loss_evt && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`endif

  always_comb begin
    pll_reset = 1'b0;
    pll_pwd   = 1'b0;
    ddr_rst   = 1'b1;
    ready     = 1'b0;
    fail      = 1'b0;
    case (state_q)
      PLL_RST: pll_reset = 1'b1;
      RUN: begin
        ddr_rst = 1'b0;
        ready   = 1'b1;
      end
      FAIL: begin
        pll_reset = 1'b1;
        pll_pwd   = 1'b1;
        fail      = 1'b1;
      end
      default: ;
    endcase
  end

  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
